// File: rtl/cart_word_writer.sv
// ---------------------------------------------------------------------------
// cart_word_writer
//
// Bridges the data_io byte stream of a cartridge download to the SDRAM
// controller's cart port. Bytes are packed big-endian into 16-bit words
// (first byte of each pair in mem_din[15:8]). Each word goes out as one
// req/ack toggle transaction. data_io is held off with ioctl_wait while a
// write is outstanding. An odd-length download is padded with 8'h00 in the
// low byte of its final word.
//
// Ports
//   clk_sys        system clock, all logic on the rising edge
//   reset          synchronous, active-high
//   ioctl_download download active (data_io)
//   ioctl_index    download index; bits [5:0] are compared against INDEX
//   ioctl_wr       one-cycle byte strobe
//   ioctl_addr     byte address of ioctl_dout (used only to spot byte 0)
//   ioctl_dout     download byte
//   ioctl_wait     stall request back to data_io
//   mem_addr       SDRAM byte address of the word being written (even)
//   mem_din        write data {high byte, low byte}
//   mem_we         write enable, held for the whole transaction
//   mem_req        request toggle
//   mem_ack        acknowledge toggle, equals mem_req when idle
//   busy           selected download in progress or write outstanding
//   done           one-cycle pulse once the download has fully drained
//   word_count     words written by the last/current download (saturating)
//   intellicart    first byte of the download was 8'hA8
//   overrun        sticky: a byte arrived while ioctl_wait was high
// ---------------------------------------------------------------------------
module cart_word_writer #(
    parameter logic [5:0]        INDEX  = 6'd1,
    parameter int                ADDR_W = 22,
    parameter logic [ADDR_W-1:0] BASE   = '0
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic              mem_we,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic [20:0]       word_count,
    output logic              intellicart,
    output logic              overrun
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] HI       = 3'd1;
    localparam logic [2:0] LO       = 3'd2;
    localparam logic [2:0] ISSUE    = 3'd3;
    localparam logic [2:0] WAIT_ACK = 3'd4;
    localparam logic [2:0] FLUSH    = 3'd5;

    logic [2:0]        state;
    logic              sel;
    logic              sel_q;
    logic              byte_stb;
    logic [7:0]        hi_byte;
    logic              flush_pend;   // the word in flight is the odd-length pad
    logic              launch;
    logic [15:0]       launch_din;
    logic [ADDR_W-1:0] word_addr;
    logic              unused_index;

    assign unused_index = ^ioctl_index[7:6];

    assign sel      = ioctl_download && (ioctl_index[5:0] == INDEX);
    assign byte_stb = ioctl_wr && sel;
    assign busy     = (state != IDLE);

    // Word n lives at BASE + 2n; the sum wraps at 2^ADDR_W.
    assign word_addr = BASE + ADDR_W'({word_count, 1'b0});

    // The transaction is launched on the LO exit edge so that mem_req and
    // ioctl_wait are already visible in the ISSUE/FLUSH cycle, i.e. one
    // cycle after the low-byte strobe. A sel fall with a high byte pending
    // launches the zero-padded word instead.
    always_comb begin
        launch     = 1'b0;
        launch_din = {hi_byte, ioctl_dout};
        if (state == LO) begin
            if (!sel) begin
                launch     = 1'b1;
                launch_din = {hi_byte, 8'h00};
            end else if (ioctl_wr) begin
                launch     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        sel_q <= sel;
        done  <= 1'b0;
        if (reset) begin
            // Matching mem_req to mem_ack cancels any pending transaction
            // from our side; a write already taken by the controller may
            // still complete, which is harmless.
            state       <= IDLE;
            mem_req     <= mem_ack;
            ioctl_wait  <= 1'b0;
            mem_we      <= 1'b0;
            overrun     <= 1'b0;
            intellicart <= 1'b0;
            word_count  <= '0;
            mem_addr    <= BASE;
            mem_din     <= '0;
            hi_byte     <= '0;
            flush_pend  <= 1'b0;
        end else begin
            // Strobes while stalled are dropped; only the flag records them.
            if (byte_stb && ioctl_wait)
                overrun <= 1'b1;

            if (launch) begin
                mem_addr   <= word_addr;
                mem_din    <= launch_din;
                mem_we     <= 1'b1;
                mem_req    <= ~mem_req;
                ioctl_wait <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (sel && !sel_q) begin
                        state       <= HI;
                        word_count  <= '0;
                        overrun     <= 1'b0;
                        intellicart <= 1'b0;
                    end
                end

                HI: begin
                    if (!sel) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else if (ioctl_wr) begin
                        hi_byte <= ioctl_dout;
                        if (ioctl_addr == 25'd0)
                            intellicart <= (ioctl_dout == 8'hA8);
                        state <= LO;
                    end
                end

                LO: begin
                    if (!sel) begin
                        flush_pend <= 1'b1;
                        state      <= FLUSH;
                    end else if (ioctl_wr) begin
                        flush_pend <= 1'b0;
                        state      <= ISSUE;
                    end
                end

                // Outputs were loaded on entry; these states only mark the
                // launch cycle before the ack wait.
                ISSUE:   state <= WAIT_ACK;
                FLUSH:   state <= WAIT_ACK;

                WAIT_ACK: begin
                    // A sel fall here does not abort the write; it only
                    // decides where to go once the ack arrives.
                    if (mem_ack == mem_req) begin
                        if (word_count != '1)
                            word_count <= word_count + 21'd1;
                        ioctl_wait <= 1'b0;
                        mem_we     <= 1'b0;
                        if (flush_pend || !sel) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            state <= HI;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cart_word_writer.sv
`timescale 1ns/1ps
module tb_cart_word_writer;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'h00;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = 8'h00;
    logic        ioctl_wait;
    logic [21:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_we;
    logic        mem_req;
    logic        mem_ack;
    logic        busy;
    logic        done;
    logic [20:0] word_count;
    logic        intellicart;
    logic        overrun;

    cart_word_writer dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .busy(busy), .done(done), .word_count(word_count),
        .intellicart(intellicart), .overrun(overrun)
    );

    always #5 clk_sys = ~clk_sys;

    // SDRAM side: acks ack_delay cycles after a request, logs each write.
    logic        resp_en = 1'b1;
    logic        ack_force = 1'b0;
    logic        ack_model = 1'b0;
    int          ack_delay = 4;
    int          ack_cnt = 0;
    logic [37:0] wr_q[$];

    assign mem_ack = resp_en ? ack_model : ack_force;

    always @(posedge clk_sys) begin
        if (!resp_en || reset) begin
            ack_model <= resp_en ? ack_model : ack_force;
            ack_cnt   <= 0;
        end else if (mem_req !== ack_model) begin
            if (ack_cnt + 1 >= ack_delay) begin
                ack_model <= mem_req;
                ack_cnt   <= 0;
                if (mem_we) wr_q.push_back({mem_addr, mem_din});
            end else begin
                ack_cnt <= ack_cnt + 1;
            end
        end
    end

    // Event counters: done pulses and mem_req toggles not caused by reset.
    int   done_cnt = 0;
    int   tog_cnt = 0;
    logic req_q = 1'b0;
    logic rst_q = 1'b1;
    always @(posedge clk_sys) begin
        req_q <= mem_req;
        rst_q <= reset;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (!reset && !rst_q && mem_req !== req_q) tog_cnt <= tog_cnt + 1;
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [21:0] cap_addr = '0;
    logic [15:0] cap_din = '0;
    int          max_wait = 0;
    logic [20:0] exp_wc = '0;
    logic        exp_ic = 1'b0;
    logic        exp_ovr = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Wait out a stall; while stalled, the write must be held steady.
    task automatic drain_wait();
        int   guard;
        logic ok;
        guard = 0;
        while (ioctl_wait === 1'b1 && guard < 300) begin
            chk("hold_we", mem_we, 1);
            chk("hold_addr", mem_addr, cap_addr);
            chk("hold_din", mem_din, cap_din);
            tick();
            guard++;
        end
        if (guard > max_wait) max_wait = guard;
        ok = (guard < 300);
        chk("wait_bound", ok, 1);
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d,
                             input bit is_lo, input bit sel_on);
        logic exp_req;
        drain_wait();
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        exp_req    = ~mem_req;
        tick();
        ioctl_wr = 1'b0;
        if (sel_on && is_lo) begin
            chk("wait_rise", ioctl_wait, 1);
            chk("req_toggle", mem_req, exp_req);
            chk("we_set", mem_we, 1);
            cap_addr = mem_addr;
            cap_din  = mem_din;
        end else if (!sel_on) begin
            chk("nosel_busy", busy, 0);
            chk("nosel_wait", ioctl_wait, 0);
        end
    endtask

    // One complete download; expected results come from the packing rule:
    // word i = {b[2i], b[2i+1] or 00} at byte address 2i.
    task automatic download(input logic [7:0] idx, input logic [7:0] bytes[$],
                            input int ovr_pos, input int max_gap);
        bit          sel_on;
        int          d0, t0, w0, guard, n_words;
        logic        ok;
        logic [7:0]  lo;
        logic [37:0] got, expw;
        sel_on = (idx[5:0] == 6'd1);
        d0 = done_cnt; t0 = tog_cnt; w0 = wr_q.size(); guard = 0;
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
        foreach (bytes[k]) begin
            repeat ($urandom_range(max_gap, 0)) tick();
            send_byte(25'(k), bytes[k], (k % 2) == 1, sel_on);
            if (k == ovr_pos && sel_on) begin
                ioctl_addr = 25'h1ffff;
                ioctl_dout = 8'h55;
                ioctl_wr   = 1'b1;
                tick();
                ioctl_wr = 1'b0;
            end
        end
        drain_wait();
        ioctl_download = 1'b0;
        while (busy === 1'b1 && guard < 300) begin
            tick();
            guard++;
        end
        ok = (guard < 300);
        chk("busy_bound", ok, 1);
        tick();

        n_words = sel_on ? (bytes.size() + 1) / 2 : 0;
        if (sel_on) begin
            exp_wc  = 21'(n_words);
            exp_ic  = (bytes[0] == 8'hA8);
            exp_ovr = (ovr_pos >= 0);
        end
        chk("done_pulses", done_cnt - d0, sel_on ? 1 : 0);
        chk("req_toggles", tog_cnt - t0, n_words);
        chk("write_count", wr_q.size() - w0, n_words);
        for (int i = 0; i < n_words; i++) begin
            lo   = (2 * i + 1 < bytes.size()) ? bytes[2 * i + 1] : 8'h00;
            expw = {22'(2 * i), bytes[2 * i], lo};
            got  = (w0 + i < wr_q.size()) ? wr_q[w0 + i] : 'x;
            chk($sformatf("word%0d", i), got, expw);
        end
        chk("word_count", word_count, exp_wc);
        chk("intellicart", intellicart, exp_ic);
        chk("overrun", overrun, exp_ovr);
        chk("idle_busy", busy, 0);
        chk("idle_wait", ioctl_wait, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] idx;
        int         n, t1;
        logic       ok;

        // Reset state
        repeat (3) tick();
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_intellicart", intellicart, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_din", mem_din, 0);
        chk("rst_req", mem_req, mem_ack);
        reset = 1'b0;
        tick();

        // Even stream
        ack_delay = 4;
        q = '{8'h12, 8'h34, 8'h56, 8'h78};
        download(8'h01, q, -1, 2);

        // Odd stream with Intellicart signature
        q = '{8'hA8, 8'h01, 8'hFF};
        download(8'h01, q, -1, 2);

        // Single byte: only a padded word
        q = '{8'h3C};
        download(8'h01, q, -1, 0);

        // Backpressure
        ack_delay = 20;
        max_wait  = 0;
        q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        download(8'h01, q, -1, 1);
        ok = (max_wait >= 20 && max_wait <= 22);
        chk("bp_wait_len", ok, 1);

        // Overrun: stray byte 55 while stalled
        ack_delay = 4;
        q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        download(8'h01, q, 1, 1);

        // Wrong index: nothing happens
        q = '{8'h01, 8'h02, 8'h03, 8'h04};
        download(8'h00, q, -1, 1);

        // Randomized streams
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(9, 1);
            q.delete();
            for (int j = 0; j < n; j++) q.push_back(8'($urandom));
            if ($urandom_range(1, 0) == 1) q[0] = 8'hA8;
            ack_delay = $urandom_range(6, 0);
            case ($urandom_range(3, 0))
                0:       idx = 8'h01;
                1:       idx = 8'hC1;
                2:       idx = 8'h41;
                default: idx = 8'h02;
            endcase
            download(idx, q, (n >= 4) ? 1 : -1, 3);
        end

        // Reset with mem_ack=1 while a write is outstanding
        resp_en   = 1'b0;
        ack_force = 1'b1;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("rst2_req_follow", mem_req, 1);
        ioctl_index    = 8'h01;
        ioctl_download = 1'b1;
        tick();
        send_byte(25'd0, 8'h11, 1'b0, 1'b1);
        send_byte(25'd1, 8'h22, 1'b1, 1'b1);
        tick();
        tick();
        chk("rst2_pending_busy", busy, 1);
        chk("rst2_pending_req", mem_req, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ioctl_download = 1'b0;
        chk("rst2_req", mem_req, 1);
        chk("rst2_busy", busy, 0);
        chk("rst2_wait", ioctl_wait, 0);
        chk("rst2_we", mem_we, 0);
        t1 = tog_cnt;
        repeat (10) tick();
        chk("rst2_no_toggle", tog_cnt - t1, 0);
        chk("rst2_req_hold", mem_req, 1);
        resp_en = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
